rle_decoder: RTL and testbench
==============================

Name: rle_decoder

Overview:
- Downstream neighbour of the DWT+RLE run-length encoder, used on the reconstruction/verification path.
- Accepts (value, run length) pairs and re-expands each pair into `count` copies of the value, one sample per cycle, restoring the DWT coefficient stream.
- Valid/ready handshake on both sides.
- Zero-bubble between consecutive runs when the sink is always ready.

Parameters:
- DW, 8, sample width; signed, two's complement.
- CW, 8, run-length width; count range 0..2^CW-1.

Ports:
- clk  input  1  system clock; all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  pair present on in_value/in_count
- in_ready  output  1  decoder accepts pair this cycle
- in_value  input  DW  signed sample value of the run
- in_count  input  CW  run length (unsigned)
- out_valid  output  1  out_data holds a valid sample
- out_ready  input  1  sink consumes sample this cycle
- out_data  output  DW  signed reconstructed sample
- out_last  output  1  high with the final sample of each run
- err_zero  output  1  one-cycle pulse: a pair with count 0 was accepted and dropped

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, val_q=0, rem_q=0.
  - out_valid=0, out_data=0, out_last=0, err_zero=0, in_ready=1 once rst_n high.
- Handshakes:
  - Input pair transfers on a rising edge with in_valid&in_ready.
  - Output sample transfers on a rising edge with out_valid&out_ready.
- Stability rules:
  - out_data, out_valid and out_last hold stable while out_valid=1 and out_ready=0.
  - in_ready never depends combinationally on in_valid.
- States:
  - IDLE: out_valid=0, in_ready=1.
  - EMIT: out_valid=1, out_data=val_q, out_last=(rem_q==1).
- Transitions:
  - IDLE, accept with count>=1: val_q<=in_value, rem_q<=in_count, go EMIT.
  - IDLE, accept with count=0: stay IDLE, err_zero=1 next cycle.
  - EMIT, output transfer with rem_q>1: rem_q<=rem_q-1.
  - EMIT, output transfer with rem_q==1 and no input transfer: go IDLE.
  - EMIT, output transfer with rem_q==1 and input transfer (count>=1): load new pair, stay EMIT. No idle cycle between runs.
  - EMIT, output transfer with rem_q==1 and input transfer (count=0): go IDLE, err_zero pulse.
  - EMIT, out_ready=0: all state held.
- in_ready = (state==IDLE) | (state==EMIT & rem_q==1 & out_ready).
- Latency and throughput:
  - Pair accepted at edge k gives first sample with out_valid=1 in the cycle after edge k.
  - A run of N occupies exactly N output-transfer cycles.
- Widths:
  - rem_q is CW bits; never decrements below 1 in EMIT, so no wrap.
  - Max count 2^CW-1 (255) emits 255 samples.
  - in_value passes through unmodified; sign preserved.
- Reset mid-run: any pending samples are discarded; returns to IDLE with outputs cleared.

Optional Feature:
- Macro: RLE_DEC_STATS_EN.
- Defined:
  - Adds output sample_total [31:0], an unsigned count of output transfers since reset.
  - Adds output run_total [15:0], counting accepted pairs with count>=1.
  - Both wrap modulo 2^width. Both reset to 0 on rst_n low.
  - Updates take effect on the same edge as the corresponding transfer.
- Undefined:
  - Neither port nor counter exists.
  - Core behaviour is identical.

Test Plan:
- Reset then single pair (value=-3, count=4), out_ready=1 -> out_data=-3 on 4 consecutive cycles starting the cycle after acceptance; out_last only on the 4th; then out_valid=0, in_ready=1.
- Back-to-back pairs (5,2),(7,1),(-128,3), in_valid held, out_ready=1 -> output stream 5,5,7,-128,-128,-128 with no gap cycles; in_ready high only in IDLE or on each run's last beat.
- Pair (9,3) with out_ready toggling 1,0,0,1,1 -> three transfers of 9; out_data/out_last stable during stalls; in_ready=0 during the stall cycles.
- Pair (4,0) in IDLE, then (6,1) -> no sample for the first pair, err_zero high one cycle after its acceptance; then a single 6 with out_last=1.
- Pair (1,255), assert rst_n low after 100 samples -> outputs cleared asynchronously, state IDLE; after release, pair (2,1) -> single sample 2.
- With RLE_DEC_STATS_EN: pairs (3,2),(4,0),(5,5) -> sample_total=7, run_total=2 after drain.

Source files
------------

// File: rtl/rle_decoder.sv
// Run-length decoder: expands (value, count) pairs into count copies of value, one per cycle.
// Optional RLE_DEC_STATS_EN adds sample_total / run_total transfer counters.
module rle_decoder #(
  parameter int unsigned DW = 8,
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_value,
  input  logic [CW-1:0] in_count,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          err_zero
`ifdef RLE_DEC_STATS_EN
  ,
  output logic [31:0]   sample_total,
  output logic [15:0]   run_total
`endif
);

  typedef enum logic [0:0] {StIdle, StEmit} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] val_q, val_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          err_q, err_d;

  logic in_xfer, out_xfer, cnt_zero, rem_one;

  assign cnt_zero = (in_count == '0);
  assign rem_one  = (rem_q == CW'(1));
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      val_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    rem_d   = rem_q;
    err_d   = in_xfer & cnt_zero;
    unique case (state_q)
      StIdle: begin
        if (in_xfer && !cnt_zero) begin
          val_d   = in_value;
          rem_d   = in_count;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_xfer) begin
          if (!rem_one) begin
            rem_d = rem_q - CW'(1);
          end else if (in_xfer && !cnt_zero) begin
            // Chain straight into the next run so consecutive runs have no bubble
            val_d = in_value;
            rem_d = in_count;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    in_ready  = 1'b0;
    err_zero  = err_q;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
      end
      StEmit: begin
        out_valid = 1'b1;
        out_data  = val_q;
        out_last  = rem_one;
        in_ready  = rem_one & out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

`ifdef RLE_DEC_STATS_EN
  logic [31:0] sample_q;
  logic [15:0] run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      run_q    <= '0;
    end else begin
      if (out_xfer) sample_q <= sample_q + 32'd1;
      if (in_xfer && !cnt_zero) run_q <= run_q + 16'd1;
    end
  end

  assign sample_total = sample_q;
  assign run_total    = run_q;
`endif

endmodule

// File: tb/tb_rle_decoder.sv
// Self-checking bench for rle_decoder: directed scenarios plus random traffic,
// scored against a queue of expected samples built from each accepted pair.
module tb_rle_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_value;
  logic [7:0] in_count;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       err_zero;
`ifdef RLE_DEC_STATS_EN
  logic [31:0] sample_total;
  logic [15:0] run_total;
`endif

  rle_decoder #(.DW(8), .CW(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_count  (in_count),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .err_zero  (err_zero)
`ifdef RLE_DEC_STATS_EN
    ,
    .sample_total (sample_total),
    .run_total    (run_total)
`endif
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Reference model: every expected output sample, in order
  logic [7:0] exp_data[$];
  bit         exp_last[$];
  bit         err_exp;
  bit         in_acc, out_acc;
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;
  int unsigned n_samples, n_runs;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_data.delete();
    exp_last.delete();
    err_exp    = 0;
    prev_stall = 0;
    in_acc     = 0;
    n_samples  = 0;
    n_runs     = 0;
  endtask

  // Check outputs at the falling edge, then advance the model past the next rising edge
  task automatic cycle();
    @(negedge clk);
    chk("out_valid", out_valid, 32'(exp_data.size() != 0));
    chk("in_ready", in_ready,
        32'((exp_data.size() == 0) || (exp_data.size() == 1 && out_ready)));
    chk("err_zero", err_zero, 32'(err_exp));
    if (prev_stall) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, prev_data);
      chk("stall_last", out_last, prev_last);
    end
    if (out_valid && exp_data.size() != 0) begin
      chk("out_data", out_data, exp_data[0]);
      chk("out_last", out_last, 32'(exp_last[0]));
    end
    in_acc  = in_valid && in_ready;
    out_acc = out_valid && out_ready;
    if (out_acc && exp_data.size() != 0) begin
      void'(exp_data.pop_front());
      void'(exp_last.pop_front());
      n_samples++;
    end
    err_exp = in_acc && (in_count == 0);
    if (in_acc && in_count != 0) begin
      for (int i = 1; i <= int'(in_count); i++) begin
        exp_data.push_back(in_value);
        exp_last.push_back(i == int'(in_count));
      end
      n_runs++;
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    @(posedge clk);
    #1;
  endtask

  task automatic send_pair(input logic [7:0] v, input logic [7:0] c, input bit hold);
    int n = 0;
    in_valid = 1'b1;
    in_value = v;
    in_count = c;
    do begin
      cycle();
      n++;
    end while (!in_acc && n < 1000);
    chk("send_accept", 32'(in_acc), 1);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while ((exp_data.size() != 0 || out_valid) && n < 2000) begin
      cycle();
      n++;
    end
    chk("drain_done", 32'(exp_data.size()), 0);
    cycle();
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] vals[3];
    logic [7:0] cnts[3];
    bit         pat[5];
    int         n;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    in_count  = '0;
    out_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err_zero", err_zero, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Single run of -3 x4
    out_ready = 1'b1;
    send_pair(8'hFD, 8'd4, 0);
    drain();

    // Back-to-back runs with in_valid held
    vals = '{8'd5, 8'd7, 8'h80};
    cnts = '{8'd2, 8'd1, 8'd3};
    for (int i = 0; i < 3; i++) send_pair(vals[i], cnts[i], 1);
    drain();

    // Stalled run
    send_pair(8'd9, 8'd3, 0);
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      out_ready = pat[i];
      cycle();
    end
    out_ready = 1'b1;
    drain();

    // Zero-count pair is dropped and flagged
    send_pair(8'd4, 8'd0, 0);
    send_pair(8'd6, 8'd1, 0);
    drain();

    // Reset in the middle of a long run
    send_pair(8'd1, 8'd255, 0);
    n = 0;
    while (n_samples < 100 && n < 500) begin
      cycle();
      n++;
    end
    chk("long_run_count", n_samples, 100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", out_valid, 0);
    chk("async_out_data", out_data, 0);
    chk("async_out_last", out_last, 0);
    chk("async_err_zero", err_zero, 0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_pair(8'd2, 8'd1, 0);
    drain();

`ifdef RLE_DEC_STATS_EN
    do_reset();
    chk("stats_rst_samples", sample_total, 0);
    chk("stats_rst_runs", 32'(run_total), 0);
    send_pair(8'd3, 8'd2, 1);
    send_pair(8'd4, 8'd0, 1);
    send_pair(8'd5, 8'd5, 0);
    drain();
    chk("stats_samples", sample_total, 7);
    chk("stats_runs", 32'(run_total), 2);
`endif

    // Random traffic
    do_reset();
    in_acc = 0;
    for (int i = 0; i < 600; i++) begin
      if (!in_valid || in_acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_value = 8'($urandom);
        in_count = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    out_ready = 1'b1;
    drain();
`ifdef RLE_DEC_STATS_EN
    chk("rand_samples", sample_total, n_samples);
    chk("rand_runs", 32'(run_total), n_runs);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
